rtds_post_stream: RTL and testbench
===================================

Name: rtds_post_stream

Overview:
- Receive side of the RTDS Aurora link. Takes the Aurora AXI-Stream master output, which has no tready, and buffers it in a parametrised FIFO so the downstream AXI-Stream consumer gets a real tready.
- Optionally strips the trailing sequence-number word of each frame, re-tagging the preceding word with tlast.
- Counts words per frame, frames, and sequence-number discontinuities. Flags FIFO overflow.

Parameters:
- DATA_WIDTH, 32, width of tdata and of the sequence-number word.
- FIFO_DEPTH, 64, FIFO entries; power of two, at least 4.
- CNT_WIDTH, 16, width of the per-frame word counter.

Ports:
- m_axis_aclk, in, 1, single clock for the whole block.
- m_axis_aresetn, in, 1, asynchronous active-low reset; release is synchronised by the integrator.
- s_axis_tvalid, in, 1, input beat valid; no backpressure is possible.
- s_axis_tdata, in, DATA_WIDTH, input data.
- s_axis_tlast, in, 1, last beat of an RTDS frame; this beat is the sequence number.
- m_axis_tvalid, out, 1, output valid.
- m_axis_tready, in, 1, downstream ready.
- m_axis_tdata, out, DATA_WIDTH, output data.
- m_axis_tlast, out, 1, last beat of the output frame.
- ctrl_strip_seq, in, 1, 1 = drop the sequence word; sampled at frame start.
- ctrl_clear, in, 1, synchronous clear of all stat_* registers; the datapath is unaffected.
- stat_cnt_words, out, CNT_WIDTH, word count of the last completed input frame, including the sequence word.
- stat_cnt_rdy, out, 1, stat_cnt_words is valid.
- stat_cnt_frames, out, 32, completed input frames; wraps.
- stat_seq, out, DATA_WIDTH, last captured sequence word.
- stat_seq_err, out, 16, count of sequence discontinuities; saturates.
- stat_overflow, out, 1, sticky: a word was dropped because the FIFO was full.
- stat_fifo_level, out, clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Behaviour:
- Reset (asynchronous, m_axis_aresetn=0):
  - All outputs are 0, the FIFO is empty and the hold register is empty.
  - The mode register is 0 and the frame state is IDLE.
  - The seq_first flag is set.
- Frame FSM:
  - IDLE→IN_FRAME on a valid beat with tlast=0.
  - IN_FRAME→IDLE on a valid beat with tlast=1.
  - A valid beat in IDLE with tlast=1 is a one-word frame and the FSM stays in IDLE.
  - The mode register loads ctrl_strip_seq on every valid beat taken in IDLE. Changes to ctrl_strip_seq mid-frame are ignored.
- Pass mode (mode=0): each valid beat is pushed to the FIFO with its own tlast, registered, so the push occurs 1 cycle after the beat.
- Strip mode (mode=1), using a one-word hold register:
  - Non-last beat: if the hold register is full, push the held word with tlast=0; then load the hold register with the beat.
  - Last beat: if the hold register is full, push the held word with tlast=1 and empty the hold register. The beat itself is not pushed and goes to sequence capture.
  - One-word frame: nothing is pushed; the word is still captured as the sequence.
  - The hold register is always empty in IDLE.
- Sequence capture, on every tlast beat regardless of mode:
  - stat_seq <= tdata.
  - If seq_first=0 and tdata != previous stat_seq+1 (mod 2^DATA_WIDTH), increment stat_seq_err.
  - seq_first <= 0 afterwards.
- Word counting:
  - The internal counter increments on every valid beat and saturates at all-ones.
  - On a tlast beat: stat_cnt_words <= counter+1 (saturating), counter <= 0, stat_cnt_frames increments, and stat_cnt_rdy <= 1.
  - stat_cnt_rdy is forced to 0 combinationally while s_axis_tvalid=1. It drops to 0 when the next frame's first beat is taken.
- FIFO:
  - First-word-fall-through. m_axis_tvalid=1 whenever occupancy > 0; data and tlast come from the head entry.
  - A pop occurs when m_axis_tvalid & m_axis_tready. Write-to-tvalid latency is 1 cycle.
  - A push is accepted if level < FIFO_DEPTH, or if level = FIFO_DEPTH with a pop in the same cycle.
  - Otherwise the push is dropped and stat_overflow is set. Later words of the frame are still processed normally.
  - Simultaneous push and pop leave the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- ctrl_clear:
  - The next cycle, every stat_* register except stat_fifo_level is 0 and seq_first is set.
  - If a tlast beat coincides with ctrl_clear, the clear wins; the in-progress word counter is also zeroed.
- Output ordering: never reorders, never duplicates. m_axis_tdata and m_axis_tlast are held stable while tvalid=1 and tready=0.

Test Plan:
- Pass mode, frame A,B,C,S1(tlast), tready=1 → output A,B,C,S1 with tlast on S1; stat_cnt_words=4, stat_cnt_frames=1, stat_seq=S1.
- Strip mode, frames D0..D3,0x10 then D0..D3,0x11 → output D0..D3 twice, tlast on D3 each time; stat_seq=0x11, stat_seq_err=0.
- Strip mode, sequence words 0x10 then 0x13 → stat_seq_err=1. Then a one-word frame 0x14 → no output, stat_seq_err stays 1, stat_cnt_words=1.
- FIFO_DEPTH=4, tready=0, 6-word pass-mode frame → level=4, stat_overflow=1, words 5 and 6 are lost. Release tready → words 1-4 are emitted.
- ctrl_strip_seq toggled mid-frame → that frame uses the mode sampled at its first beat; the next frame uses the new mode.
- Assert m_axis_aresetn mid-frame with the FIFO at level 3 → all outputs 0 immediately. After release, a clean 3-word frame passes and stat_cnt_frames=1.

Source files
------------

// File: rtl/rtds_post_stream.sv
// Generic first-word-fall-through FIFO, single clock, power-of-two depth.
// Latency: a push shows up on pop_vld one cycle later.
// Backpressure: push_rdy drops only when full and not popping in the same cycle.
module rtds_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 64,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   output logic             push_rdy,
   output logic             pop_vld,
   output logic [WIDTH-1:0] pop_dat,
   input  logic             pop_rdy,
   output logic [AW:0]      level
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             push, pop;

   assign pop_vld  = (level_q != '0);
   assign pop      = pop_vld & pop_rdy;
   assign push_rdy = (level_q != (AW+1)'(DEPTH)) | pop;
   assign push     = push_vld & push_rdy;
   assign pop_dat  = mem_q[rd_ptr_q];
   assign level    = level_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + (AW+1)'(1);
      else if (pop && !push) level_d = level_q - (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_dat;
   end
endmodule

// RTDS Aurora receive: buffers the tready-less stream, optionally strips the sequence word, keeps stats.
// Latency: input beat to m_axis_tvalid is 2 cycles (registered push, then FIFO write).
// Backpressure: m_axis_tready stalls the FIFO only; a full FIFO drops words and sets stat_overflow.
module rtds_post_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 64,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          m_axis_aclk,
   input  logic                          m_axis_aresetn,
   input  logic                          s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
   input  logic                          s_axis_tlast,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tlast,
   input  logic                          ctrl_strip_seq,
   input  logic                          ctrl_clear,
   output logic [CNT_WIDTH-1:0]          stat_cnt_words,
   output logic                          stat_cnt_rdy,
   output logic [31:0]                   stat_cnt_frames,
   output logic [DATA_WIDTH-1:0]         stat_seq,
   output logic [15:0]                   stat_seq_err,
   output logic                          stat_overflow,
   output logic [$clog2(FIFO_DEPTH):0]   stat_fifo_level
);
   typedef enum logic {IDLE, IN_FRAME} state_t;

   typedef struct packed {
      logic                  last;
      logic [DATA_WIDTH-1:0] dat;
   } beat_t;

   state_t                state_q, state_d;
   logic                  mode_q, mode_d;
   logic                  hold_vld_q, hold_vld_d;
   logic [DATA_WIDTH-1:0] hold_dat_q, hold_dat_d;
   logic                  push_vld_q, push_vld_d;
   beat_t                 push_beat_q, push_beat_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [CNT_WIDTH-1:0]  cnt_words_q, cnt_words_d;
   logic                  cnt_rdy_q, cnt_rdy_d;
   logic [31:0]           frames_q, frames_d;
   logic [DATA_WIDTH-1:0] seq_q, seq_d;
   logic [15:0]           seq_err_q, seq_err_d;
   logic                  seq_first_q, seq_first_d;
   logic                  overflow_q, overflow_d;
   logic                  eff_mode;
   logic                  fifo_push_rdy;
   beat_t                 head;

   rtds_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (m_axis_aclk),
      .rst_n    (m_axis_aresetn),
      .push_vld (push_vld_q),
      .push_dat (push_beat_q),
      .push_rdy (fifo_push_rdy),
      .pop_vld  (m_axis_tvalid),
      .pop_dat  (head),
      .pop_rdy  (m_axis_tready),
      .level    (stat_fifo_level)
   );

   // Head entry is masked so an empty FIFO presents all-zero data.
   assign m_axis_tdata = m_axis_tvalid ? head.dat  : '0;
   assign m_axis_tlast = m_axis_tvalid & head.last;

   // The first beat of a frame already obeys the mode being loaded with it.
   assign eff_mode = (state_q == IDLE) ? ctrl_strip_seq : mode_q;
   assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      hold_vld_d  = hold_vld_q;
      hold_dat_d  = hold_dat_q;
      push_vld_d  = 1'b0;
      push_beat_d = push_beat_q;
      cnt_d       = cnt_q;
      cnt_words_d = cnt_words_q;
      cnt_rdy_d   = cnt_rdy_q;
      frames_d    = frames_q;
      seq_d       = seq_q;
      seq_err_d   = seq_err_q;
      seq_first_d = seq_first_q;
      overflow_d  = overflow_q;

      if (s_axis_tvalid) begin
         if (state_q == IDLE) mode_d = ctrl_strip_seq;
         state_d = s_axis_tlast ? IDLE : IN_FRAME;

         if (!eff_mode) begin
            push_vld_d  = 1'b1;
            push_beat_d = '{last: s_axis_tlast, dat: s_axis_tdata};
         end else if (!s_axis_tlast) begin
            if (hold_vld_q) begin
               push_vld_d  = 1'b1;
               push_beat_d = '{last: 1'b0, dat: hold_dat_q};
            end
            hold_vld_d = 1'b1;
            hold_dat_d = s_axis_tdata;
         end else begin
            if (hold_vld_q) begin
               push_vld_d  = 1'b1;
               push_beat_d = '{last: 1'b1, dat: hold_dat_q};
            end
            hold_vld_d = 1'b0;
         end

         if (s_axis_tlast) begin
            cnt_words_d = cnt_inc;
            cnt_d       = '0;
            frames_d    = frames_q + 32'd1;
            cnt_rdy_d   = 1'b1;
            seq_d       = s_axis_tdata;
            seq_first_d = 1'b0;
            if (!seq_first_q && (s_axis_tdata != seq_q + DATA_WIDTH'(1)) && (seq_err_q != '1))
               seq_err_d = seq_err_q + 16'd1;
         end else begin
            cnt_d     = cnt_inc;
            cnt_rdy_d = 1'b0;
         end
      end

      if (push_vld_q && !fifo_push_rdy) overflow_d = 1'b1;

      if (ctrl_clear) begin
         cnt_words_d = '0;
         cnt_rdy_d   = 1'b0;
         frames_d    = '0;
         seq_d       = '0;
         seq_err_d   = '0;
         seq_first_d = 1'b1;
         overflow_d  = 1'b0;
      end
   end

   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         hold_vld_q  <= 1'b0;
         hold_dat_q  <= '0;
         push_vld_q  <= 1'b0;
         push_beat_q <= '0;
         cnt_q       <= '0;
         cnt_words_q <= '0;
         cnt_rdy_q   <= 1'b0;
         frames_q    <= '0;
         seq_q       <= '0;
         seq_err_q   <= '0;
         seq_first_q <= 1'b1;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         hold_vld_q  <= hold_vld_d;
         hold_dat_q  <= hold_dat_d;
         push_vld_q  <= push_vld_d;
         push_beat_q <= push_beat_d;
         cnt_q       <= cnt_d;
         cnt_words_q <= cnt_words_d;
         cnt_rdy_q   <= cnt_rdy_d;
         frames_q    <= frames_d;
         seq_q       <= seq_d;
         seq_err_q   <= seq_err_d;
         seq_first_q <= seq_first_d;
         overflow_q  <= overflow_d;
      end
   end

   // A new frame's first beat hides the previous count before the register catches up.
   assign stat_cnt_rdy    = cnt_rdy_q & ~s_axis_tvalid;
   assign stat_cnt_words  = cnt_words_q;
   assign stat_cnt_frames = frames_q;
   assign stat_seq        = seq_q;
   assign stat_seq_err    = seq_err_q;
   assign stat_overflow   = overflow_q;
endmodule

// File: tb/tb_rtds_post_stream.sv
// Directed bench for rtds_post_stream with a 4-deep FIFO and a 3-bit word counter.
module tb_rtds_post_stream;
   localparam int DW = 32;
   localparam int DEPTH = 4;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_axis_tvalid = 1'b0;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          s_axis_tlast = 1'b0;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tlast;
   logic          ctrl_strip_seq = 1'b0;
   logic          ctrl_clear = 1'b0;
   logic [CW-1:0] stat_cnt_words;
   logic          stat_cnt_rdy;
   logic [31:0]   stat_cnt_frames;
   logic [DW-1:0] stat_seq;
   logic [15:0]   stat_seq_err;
   logic          stat_overflow;
   logic [2:0]    stat_fifo_level;

   int n_checks = 0;
   int n_fail = 0;
   logic [DW:0] got_q[$];

   always #5 clk = ~clk;

   rtds_post_stream #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .m_axis_aclk(clk), .m_axis_aresetn(rst_n),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
      .ctrl_strip_seq(ctrl_strip_seq), .ctrl_clear(ctrl_clear),
      .stat_cnt_words(stat_cnt_words), .stat_cnt_rdy(stat_cnt_rdy),
      .stat_cnt_frames(stat_cnt_frames), .stat_seq(stat_seq),
      .stat_seq_err(stat_seq_err), .stat_overflow(stat_overflow),
      .stat_fifo_level(stat_fifo_level)
   );

   // Inputs change 1 ns after posedge, so the negedge sees the handshake of the coming edge.
   always @(negedge clk) begin
      if (rst_n && m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
   end

   task automatic beat(input logic [DW-1:0] d, input logic l);
      s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = l;
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      ctrl_clear = 1'b1;
      @(posedge clk); #1;
      ctrl_clear = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, stat_cnt_words, stat_cnt_rdy, stat_cnt_frames, stat_seq, stat_seq_err, stat_overflow, stat_fifo_level} !== '0) begin n_fail++; $display("FAIL reset_outputs: got nonzero tvalid=%b tdata=%h frames=%0d level=%0d, expected all 0", m_axis_tvalid, m_axis_tdata, stat_cnt_frames, stat_fifo_level); end
      rst_n = 1'b1;
      idle(1);
   endtask

   task automatic test_pass();
      logic [DW:0] exp [4] = '{33'h0_A000_0001, 33'h0_B000_0002, 33'h0_C000_0003, 33'h1_0000_0005};
      logic [DW:0] act;
      m_axis_tready = 1'b1; ctrl_strip_seq = 1'b0; got_q.delete();
      beat(32'hA000_0001, 0); beat(32'hB000_0002, 0); beat(32'hC000_0003, 0); beat(32'h0000_0005, 1);
      idle(6);
      n_checks++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL pass_count: got %0d expected 4", got_q.size()); end
      for (int i = 0; i < 4; i++) begin
         act = (i < got_q.size()) ? got_q[i] : 'x;
         n_checks++; if (act !== exp[i]) begin n_fail++; $display("FAIL pass_word%0d: got %h expected %h", i, act, exp[i]); end
      end
      n_checks++; if (stat_cnt_words !== 3'd4) begin n_fail++; $display("FAIL pass_cnt_words: got %0d expected 4", stat_cnt_words); end
      n_checks++; if (stat_cnt_frames !== 32'd1) begin n_fail++; $display("FAIL pass_frames: got %0d expected 1", stat_cnt_frames); end
      n_checks++; if (stat_seq !== 32'h5) begin n_fail++; $display("FAIL pass_seq: got %h expected 5", stat_seq); end
      n_checks++; if (stat_cnt_rdy !== 1'b1) begin n_fail++; $display("FAIL pass_cnt_rdy: got %b expected 1", stat_cnt_rdy); end
   endtask

   task automatic test_strip_back_to_back();
      logic [DW:0] exp [8] = '{33'h0_D000_0000, 33'h0_D000_0001, 33'h0_D000_0002, 33'h1_D000_0003,
                               33'h0_D000_0000, 33'h0_D000_0001, 33'h0_D000_0002, 33'h1_D000_0003};
      logic [DW:0] act;
      pulse_clear();
      n_checks++; if ({stat_cnt_frames, stat_seq, stat_cnt_rdy} !== '0) begin n_fail++; $display("FAIL clear_stats: got frames=%0d seq=%h rdy=%b expected 0", stat_cnt_frames, stat_seq, stat_cnt_rdy); end
      ctrl_strip_seq = 1'b1; got_q.delete();
      for (int f = 0; f < 2; f++) begin
         for (int w = 0; w < 4; w++) beat(32'hD000_0000 + w, 0);
         beat(32'h10 + f, 1);
      end
      idle(6);
      n_checks++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL strip_count: got %0d expected 8", got_q.size()); end
      for (int i = 0; i < 8; i++) begin
         act = (i < got_q.size()) ? got_q[i] : 'x;
         n_checks++; if (act !== exp[i]) begin n_fail++; $display("FAIL strip_word%0d: got %h expected %h", i, act, exp[i]); end
      end
      n_checks++; if (stat_seq !== 32'h11) begin n_fail++; $display("FAIL strip_seq: got %h expected 11", stat_seq); end
      n_checks++; if (stat_seq_err !== 16'd0) begin n_fail++; $display("FAIL strip_seq_err: got %0d expected 0", stat_seq_err); end
      n_checks++; if (stat_cnt_words !== 3'd5) begin n_fail++; $display("FAIL strip_cnt_words: got %0d expected 5", stat_cnt_words); end
      n_checks++; if (stat_cnt_frames !== 32'd2) begin n_fail++; $display("FAIL strip_frames: got %0d expected 2", stat_cnt_frames); end
   endtask

   task automatic test_seq_err();
      logic [DW:0] act;
      pulse_clear(); got_q.delete(); ctrl_strip_seq = 1'b1;
      beat(32'hE000_0000, 0); beat(32'h10, 1);
      beat(32'hE000_0001, 0); beat(32'h13, 1);
      idle(6);
      n_checks++; if (stat_seq_err !== 16'd1) begin n_fail++; $display("FAIL seq_err_gap: got %0d expected 1", stat_seq_err); end
      n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL seq_out_count: got %0d expected 2", got_q.size()); end
      act = (got_q.size() > 1) ? got_q[1] : 'x;
      n_checks++; if (act !== 33'h1_E000_0001) begin n_fail++; $display("FAIL seq_out_word1: got %h expected 1e0000001", act); end
      got_q.delete();
      beat(32'h14, 1);
      idle(5);
      n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL one_word_output: got %0d words expected 0", got_q.size()); end
      n_checks++; if (stat_seq_err !== 16'd1) begin n_fail++; $display("FAIL one_word_seq_err: got %0d expected 1", stat_seq_err); end
      n_checks++; if (stat_cnt_words !== 3'd1) begin n_fail++; $display("FAIL one_word_cnt: got %0d expected 1", stat_cnt_words); end
      n_checks++; if (stat_seq !== 32'h14) begin n_fail++; $display("FAIL one_word_seq: got %h expected 14", stat_seq); end
      n_checks++; if (stat_cnt_frames !== 32'd3) begin n_fail++; $display("FAIL one_word_frames: got %0d expected 3", stat_cnt_frames); end
   endtask

   task automatic test_overflow();
      logic [DW:0] act;
      pulse_clear(); got_q.delete(); ctrl_strip_seq = 1'b0; m_axis_tready = 1'b0;
      for (int w = 1; w <= 6; w++) beat(32'h0000_0A00 + w, (w == 6));
      idle(3);
      n_checks++; if (stat_fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d expected 4", stat_fifo_level); end
      n_checks++; if (stat_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", stat_overflow); end
      n_checks++; if (stat_cnt_words !== 3'd6) begin n_fail++; $display("FAIL ovf_cnt_words: got %0d expected 6", stat_cnt_words); end
      n_checks++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {2'b10, 32'h0000_0A01}) begin n_fail++; $display("FAIL ovf_stall_head: got v=%b l=%b d=%h expected v=1 l=0 d=00000a01", m_axis_tvalid, m_axis_tlast, m_axis_tdata); end
      n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL ovf_stalled_out: got %0d words expected 0", got_q.size()); end
      m_axis_tready = 1'b1;
      idle(8);
      n_checks++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL ovf_drain_count: got %0d expected 4", got_q.size()); end
      for (int i = 0; i < 4; i++) begin
         act = (i < got_q.size()) ? got_q[i] : 'x;
         n_checks++; if (act !== 33'h0_0000_0A01 + i) begin n_fail++; $display("FAIL ovf_word%0d: got %h expected %h", i, act, 33'h0_0000_0A01 + i); end
      end
      n_checks++; if (stat_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", stat_overflow); end
      n_checks++; if (stat_fifo_level !== 3'd0) begin n_fail++; $display("FAIL ovf_drained_level: got %0d expected 0", stat_fifo_level); end
   endtask

   task automatic test_full_pop();
      logic [DW:0] act;
      pulse_clear(); got_q.delete(); m_axis_tready = 1'b0;
      n_checks++; if (stat_overflow !== 1'b0) begin n_fail++; $display("FAIL clear_overflow: got %b expected 0", stat_overflow); end
      for (int w = 1; w <= 4; w++) beat(32'h0000_0B00 + w, 0);
      idle(2);
      beat(32'h0000_0B05, 0);
      m_axis_tready = 1'b1;
      beat(32'h0000_0B06, 1);
      n_checks++; if (stat_fifo_level !== 3'd4) begin n_fail++; $display("FAIL full_pop_level: got %0d expected 4", stat_fifo_level); end
      idle(8);
      n_checks++; if (stat_overflow !== 1'b0) begin n_fail++; $display("FAIL full_pop_overflow: got %b expected 0", stat_overflow); end
      n_checks++; if (got_q.size() !== 6) begin n_fail++; $display("FAIL full_pop_count: got %0d expected 6", got_q.size()); end
      for (int i = 0; i < 6; i++) begin
         act = (i < got_q.size()) ? got_q[i] : 'x;
         n_checks++; if (act !== {(i == 5), 32'h0000_0B01 + i}) begin n_fail++; $display("FAIL full_pop_word%0d: got %h expected %h", i, act, {(i == 5), 32'h0000_0B01 + i}); end
      end
   endtask

   task automatic test_mode_toggle();
      logic [DW:0] exp [6] = '{33'h0_F000_0000, 33'h0_F000_0001, 33'h0_F000_0002, 33'h1_0000_0020,
                               33'h0_6000_0000, 33'h1_6000_0001};
      logic [DW:0] act;
      pulse_clear(); got_q.delete(); m_axis_tready = 1'b1; ctrl_strip_seq = 1'b0;
      beat(32'hF000_0000, 0);
      ctrl_strip_seq = 1'b1;
      beat(32'hF000_0001, 0); beat(32'hF000_0002, 0); beat(32'h0000_0020, 1);
      beat(32'h6000_0000, 0); beat(32'h6000_0001, 0); beat(32'h0000_0021, 1);
      idle(6);
      n_checks++; if (got_q.size() !== 6) begin n_fail++; $display("FAIL toggle_count: got %0d expected 6", got_q.size()); end
      for (int i = 0; i < 6; i++) begin
         act = (i < got_q.size()) ? got_q[i] : 'x;
         n_checks++; if (act !== exp[i]) begin n_fail++; $display("FAIL toggle_word%0d: got %h expected %h", i, act, exp[i]); end
      end
      n_checks++; if (stat_seq_err !== 16'd0) begin n_fail++; $display("FAIL toggle_seq_err: got %0d expected 0", stat_seq_err); end
      n_checks++; if (stat_cnt_words !== 3'd3) begin n_fail++; $display("FAIL toggle_cnt_words: got %0d expected 3", stat_cnt_words); end
   endtask

   task automatic test_cnt_sat();
      logic [DW:0] act;
      got_q.delete(); ctrl_strip_seq = 1'b0; m_axis_tready = 1'b1;
      n_checks++; if (stat_cnt_rdy !== 1'b1) begin n_fail++; $display("FAIL rdy_idle: got %b expected 1", stat_cnt_rdy); end
      s_axis_tvalid = 1'b1; s_axis_tdata = 32'h0000_0C00; s_axis_tlast = 1'b0;
      #1;
      n_checks++; if (stat_cnt_rdy !== 1'b0) begin n_fail++; $display("FAIL rdy_masked: got %b expected 0", stat_cnt_rdy); end
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      #1;
      n_checks++; if (stat_cnt_rdy !== 1'b0) begin n_fail++; $display("FAIL rdy_dropped: got %b expected 0", stat_cnt_rdy); end
      for (int w = 1; w <= 8; w++) beat(32'h0000_0C00 + w, (w == 8));
      idle(6);
      n_checks++; if (stat_cnt_words !== 3'd7) begin n_fail++; $display("FAIL cnt_saturate: got %0d expected 7", stat_cnt_words); end
      n_checks++; if (stat_cnt_frames !== 32'd3) begin n_fail++; $display("FAIL sat_frames: got %0d expected 3", stat_cnt_frames); end
      n_checks++; if (got_q.size() !== 9) begin n_fail++; $display("FAIL sat_count: got %0d expected 9", got_q.size()); end
      act = (got_q.size() > 8) ? got_q[8] : 'x;
      n_checks++; if (act !== 33'h1_0000_0C08) begin n_fail++; $display("FAIL sat_last_word: got %h expected 100000c08", act); end
   endtask

   task automatic test_reset_mid();
      logic [DW:0] act;
      m_axis_tready = 1'b0; ctrl_strip_seq = 1'b0;
      beat(32'h0000_0D00, 0); beat(32'h0000_0D01, 0); beat(32'h0000_0D02, 0);
      idle(2);
      n_checks++; if (stat_fifo_level !== 3'd3) begin n_fail++; $display("FAIL mid_level: got %0d expected 3", stat_fifo_level); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, stat_cnt_words, stat_cnt_rdy, stat_cnt_frames, stat_seq, stat_seq_err, stat_overflow, stat_fifo_level} !== '0) begin n_fail++; $display("FAIL mid_reset_outputs: got tvalid=%b tdata=%h frames=%0d level=%0d, expected all 0", m_axis_tvalid, m_axis_tdata, stat_cnt_frames, stat_fifo_level); end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      m_axis_tready = 1'b1; got_q.delete();
      beat(32'h0000_0E00, 0); beat(32'h0000_0E01, 0); beat(32'h0000_0E02, 1);
      idle(6);
      n_checks++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL post_reset_count: got %0d expected 3", got_q.size()); end
      for (int i = 0; i < 3; i++) begin
         act = (i < got_q.size()) ? got_q[i] : 'x;
         n_checks++; if (act !== {(i == 2), 32'h0000_0E00 + i}) begin n_fail++; $display("FAIL post_reset_word%0d: got %h expected %h", i, act, {(i == 2), 32'h0000_0E00 + i}); end
      end
      n_checks++; if (stat_cnt_frames !== 32'd1) begin n_fail++; $display("FAIL post_reset_frames: got %0d expected 1", stat_cnt_frames); end
      n_checks++; if (stat_cnt_words !== 3'd3) begin n_fail++; $display("FAIL post_reset_cnt_words: got %0d expected 3", stat_cnt_words); end
   endtask

   initial begin
      test_reset();
      test_pass();
      test_strip_back_to_back();
      test_seq_err();
      test_overflow();
      test_full_pop();
      test_mode_toggle();
      test_cnt_sat();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
